// File: rtl/rvv_pkg.sv
// Shared vector-unit definitions: VLEN, legal SEW/LMUL encodings,
// log2 helpers and the strip sequencer state type.
package rvv_pkg;

  localparam int VLEN = 128;

  localparam logic [7:0] SEW_8  = 8'd8;
  localparam logic [7:0] SEW_16 = 8'd16;
  localparam logic [7:0] SEW_32 = 8'd32;
  localparam logic [7:0] SEW_64 = 8'd64;

  localparam logic [4:0] LMUL_1  = 5'd1;
  localparam logic [4:0] LMUL_2  = 5'd2;
  localparam logic [4:0] LMUL_4  = 5'd4;
  localparam logic [4:0] LMUL_8  = 5'd8;
  localparam logic [4:0] LMUL_16 = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE
  } strip_state_t;

  function automatic logic [2:0] sew_log2(input logic [7:0] sew);
    logic [2:0] r;
    unique case (1'b1)
      sew == SEW_8:  r = 3'd3;
      sew == SEW_16: r = 3'd4;
      sew == SEW_32: r = 3'd5;
      sew == SEW_64: r = 3'd6;
      default:       r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] lmul_log2(input logic [4:0] lmul);
    logic [2:0] r;
    unique case (1'b1)
      lmul == LMUL_1:  r = 3'd0;
      lmul == LMUL_2:  r = 3'd1;
      lmul == LMUL_4:  r = 3'd2;
      lmul == LMUL_8:  r = 3'd3;
      lmul == LMUL_16: r = 3'd4;
      default:         r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic sew_legal(input logic [7:0] sew);
    return (sew == SEW_8) || (sew == SEW_16) ||
           (sew == SEW_32) || (sew == SEW_64);
  endfunction

  function automatic logic lmul_legal(input logic [4:0] lmul);
    return (lmul == LMUL_1) || (lmul == LMUL_2) ||
           (lmul == LMUL_4) || (lmul == LMUL_8) ||
           (lmul == LMUL_16);
  endfunction

endpackage

// File: rtl/vlmax_calc.sv
// VLMAX = (VLEN/SEW)*LMUL built from two shifts; legal flags
// any SEW/LMUL outside the supported encodings.
module vlmax_calc #(
  parameter int VLEN = rvv_pkg::VLEN,
  parameter int VL_W = 9
) (
  input  logic [7:0]      sew,
  input  logic [4:0]      lmul,
  output logic [VL_W-1:0] vlmax,
  output logic            legal
);
  import rvv_pkg::*;

  logic [VL_W-1:0] base;

  assign base  = VL_W'(VLEN) >> sew_log2(sew);
  assign vlmax = base << lmul_log2(lmul);
  assign legal = sew_legal(sew) & lmul_legal(lmul);

endmodule

// File: rtl/strip_sequencer.sv
// Strip-mining sequencer: turns one (SEW, LMUL, AVL) request into
// a stream of registered (vl, offset, last) strip descriptors.
module strip_sequencer #(
  parameter int VLEN  = rvv_pkg::VLEN,
  parameter int AVL_W = 16,
  parameter int VL_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_sew,
  input  logic [4:0]       req_lmul,
  input  logic [AVL_W-1:0] req_avl,
  input  logic             abort,
  output logic             strip_valid,
  input  logic             strip_ready,
  output logic [VL_W-1:0]  strip_vl,
  output logic [AVL_W-1:0] strip_offset,
  output logic             strip_last,
  output logic             done,
  output logic             err,
  output logic             busy
);
  import rvv_pkg::*;

  strip_state_t     state;
  logic [7:0]       sew_q;
  logic [4:0]       lmul_q;
  logic [AVL_W-1:0] rem_q;
  logic [VL_W-1:0]  vlmax_q;
  logic [VL_W-1:0]  vlmax_c;
  logic             legal_c;
  logic             hs;
  logic [AVL_W-1:0] rem_n;
  logic [AVL_W-1:0] off_n;

  vlmax_calc #(
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) u_vlmax (
    .sew   (sew_q),
    .lmul  (lmul_q),
    .vlmax (vlmax_c),
    .legal (legal_c)
  );

  function automatic logic [VL_W-1:0] clip(
    input logic [AVL_W-1:0] r,
    input logic [VL_W-1:0]  m
  );
    return (r < AVL_W'(m)) ? r[VL_W-1:0] : m;
  endfunction

  assign hs        = strip_valid & strip_ready;
  assign rem_n     = rem_q - AVL_W'(strip_vl);
  assign off_n     = strip_offset + AVL_W'(strip_vl);
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sew_q        <= '0;
      lmul_q       <= '0;
      rem_q        <= '0;
      vlmax_q      <= '0;
      strip_valid  <= 1'b0;
      strip_vl     <= '0;
      strip_offset <= '0;
      strip_last   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            sew_q        <= req_sew;
            lmul_q       <= req_lmul;
            rem_q        <= req_avl;
            strip_offset <= '0;
            state        <= S_CALC;
          end
        end
        S_CALC: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (!legal_c) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (rem_q == '0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            vlmax_q     <= vlmax_c;
            strip_valid <= 1'b1;
            strip_vl    <= clip(rem_q, vlmax_c);
            strip_last  <= rem_q <= AVL_W'(vlmax_c);
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (hs) begin
            rem_q <= rem_n;
          end
          // a handshake coinciding with abort still retires that strip
          if (abort || (hs && strip_last)) begin
            done         <= !abort;
            strip_valid  <= 1'b0;
            strip_vl     <= '0;
            strip_offset <= '0;
            strip_last   <= 1'b0;
            state        <= S_IDLE;
          end else if (hs) begin
            strip_vl     <= clip(rem_n, vlmax_q);
            strip_offset <= off_n;
            strip_last   <= rem_n <= AVL_W'(vlmax_q);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strip_sequencer.sv
// Self-checking bench for strip_sequencer: directed test-plan cases
// plus randomized jobs against a plain-arithmetic strip model.
module tb_strip_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_sew = '0;
  logic [4:0]  req_lmul = '0;
  logic [15:0] req_avl = '0;
  logic        abort = 1'b0;
  logic        strip_valid;
  logic        strip_ready = 1'b0;
  logic [8:0]  strip_vl;
  logic [15:0] strip_offset;
  logic        strip_last;
  logic        done;
  logic        err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  strip_sequencer #(
    .VLEN  (128),
    .AVL_W (16),
    .VL_W  (9)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sew      (req_sew),
    .req_lmul     (req_lmul),
    .req_avl      (req_avl),
    .abort        (abort),
    .strip_valid  (strip_valid),
    .strip_ready  (strip_ready),
    .strip_vl     (strip_vl),
    .strip_offset (strip_offset),
    .strip_last   (strip_last),
    .done         (done),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 1);
    check({tag, "_strip_valid"}, 32'(strip_valid), 0);
    check({tag, "_strip_vl"}, 32'(strip_vl), 0);
    check({tag, "_strip_offset"}, 32'(strip_offset), 0);
    check({tag, "_strip_last"}, 32'(strip_last), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle T+2.
  task automatic start_req(input int sew, input int lmul, input int avl);
    check("idle_req_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_sew   = 8'(sew);
    req_lmul  = 5'(lmul);
    req_avl   = 16'(avl);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("calc_busy", 32'(busy), 1);
    check("calc_req_ready", 32'(req_ready), 0);
    check("calc_strip_valid", 32'(strip_valid), 0);
    check("calc_done", 32'(done), 0);
    @(negedge clk);
  endtask

  task automatic run_job(input int sew, input int lmul, input int avl,
                         input int stall_first, input bit rnd);
    bit ok;
    int vm, rem, off, vl, n;
    bit rdy;
    ok = (sew inside {8, 16, 32, 64}) && (lmul inside {1, 2, 4, 8, 16});
    vm = ok ? (128 / sew) * lmul : 0;
    start_req(sew, lmul, avl);
    if (!ok) begin
      check("illegal_err", 32'(err), 1);
      check("illegal_req_ready", 32'(req_ready), 1);
      check("illegal_strip_valid", 32'(strip_valid), 0);
      check("illegal_done", 32'(done), 0);
      @(negedge clk);
      check("illegal_err_pulse", 32'(err), 0);
      check("illegal_strip_valid2", 32'(strip_valid), 0);
      return;
    end
    if (avl == 0) begin
      check("zero_done", 32'(done), 1);
      check("zero_err", 32'(err), 0);
      check("zero_req_ready", 32'(req_ready), 1);
      check("zero_strip_valid", 32'(strip_valid), 0);
      return;
    end
    rem = avl;
    off = 0;
    n = 0;
    while (rem > 0) begin
      vl = (rem < vm) ? rem : vm;
      check("strip_valid", 32'(strip_valid), 1);
      check("strip_vl", 32'(strip_vl), vl);
      check("strip_offset", 32'(strip_offset), off);
      check("strip_last", 32'(strip_last), (rem <= vm) ? 1 : 0);
      check("strip_done_low", 32'(done), 0);
      if (n < stall_first) rdy = 1'b0;
      else if (rnd) rdy = ($urandom % 3) != 0;
      else rdy = 1'b1;
      n++;
      strip_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        rem -= vl;
        off += vl;
      end
      if (n > 4000) begin
        check("job_cycle_budget", 1, 0);
        break;
      end
    end
    strip_ready = 1'b0;
    check("end_done", 32'(done), 1);
    check("end_req_ready", 32'(req_ready), 1);
    check("end_strip_valid", 32'(strip_valid), 0);
  endtask

  initial begin
    int sews[6];
    int lmuls[6];
    sews  = '{8, 16, 32, 64, 44, 64};
    lmuls = '{1, 2, 4, 8, 16, 5};

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");

    run_job(64, 4, 9, 0, 1'b0);
    run_job(8, 16, 500, 0, 1'b0);
    run_job(44, 2, 5, 0, 1'b0);
    run_job(64, 5, 5, 0, 1'b0);
    run_job(8, 1, 0, 0, 1'b0);
    run_job(32, 1, 10, 3, 1'b0);

    // abort while the second strip is presented
    start_req(16, 2, 100);
    check("ab_vl0", 32'(strip_vl), 16);
    strip_ready = 1'b1;
    @(negedge clk);
    strip_ready = 1'b0;
    check("ab_off1", 32'(strip_offset), 16);
    check("ab_valid1", 32'(strip_valid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_strip_valid", 32'(strip_valid), 0);
    check("ab_done", 32'(done), 0);
    check("ab_req_ready", 32'(req_ready), 1);
    check("ab_busy", 32'(busy), 0);
    @(negedge clk);
    check("ab_done_after", 32'(done), 0);

    // abort together with a handshake
    start_req(16, 2, 100);
    strip_ready = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    strip_ready = 1'b0;
    check("abhs_strip_valid", 32'(strip_valid), 0);
    check("abhs_done", 32'(done), 0);
    check("abhs_req_ready", 32'(req_ready), 1);
    run_job(16, 2, 20, 0, 1'b0);

    // asynchronous reset mid-job
    start_req(16, 2, 100);
    strip_ready = 1'b1;
    @(negedge clk);
    strip_ready = 1'b0;
    check("rst_valid_before", 32'(strip_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midjob_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("midjob_reset_release");

    for (int j = 0; j < 40; j++) begin
      int s, l, a;
      s = sews[$urandom_range(0, 5)];
      l = lmuls[$urandom_range(0, 5)];
      a = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 300);
      run_job(s, l, a, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
